// File: rtl/ir_pkg.sv
// Shared definitions for the IR receive path: FSM encoding, clock rate,
// default timing windows and small helpers.
package ir_pkg;

  localparam int IR_CLK_HZ         = 10000;
  localparam int TIMER_W           = 11;
  localparam int DEF_TIMEOUT       = 2000;
  localparam int DEF_REPEAT_WINDOW = 1100;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_INV = 1'b1
  } ir_state_e;

  function automatic logic is_complement(input logic [7:0] a, input logic [7:0] b);
    return ((a ^ b) == 8'hFF);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : (v + 4'h1);
  endfunction

endpackage

// File: rtl/ir_edge_detect.sv
// Rising-edge pulse generator. The history flop resets high so a level that
// is already asserted when reset releases does not produce an edge.
module ir_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic level_d;

  // next history value
  always_comb begin
    level_d = level;
  end

  // history register
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_d;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/ir_cmd_decoder.sv
// Pairs reader bytes into command/complement frames, detects auto-repeat and
// hands validated commands to the control logic over a valid/ack handshake.
module ir_cmd_decoder
  import ir_pkg::*;
#(
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int REPEAT_WINDOW = DEF_REPEAT_WINDOW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       avail,
  input  logic [7:0] ir_byte,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_repeat,
  output logic       frame_err,
  output logic       overrun,
  output logic [3:0] err_count,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RPT_MAX  = TIMER_W'(REPEAT_WINDOW);

  logic byte_evt;

  ir_state_e          state_q,        state_d;
  logic [7:0]         first_byte_q,   first_byte_d;
  logic [TIMER_W-1:0] timer_q,        timer_d;
  logic [TIMER_W-1:0] rep_timer_q,    rep_timer_d;
  logic               repeat_armed_q, repeat_armed_d;
  logic [7:0]         last_cmd_q,     last_cmd_d;
  logic               cmd_valid_q,    cmd_valid_d;
  logic [7:0]         cmd_data_q,     cmd_data_d;
  logic               cmd_repeat_q,   cmd_repeat_d;
  logic               frame_err_q,    frame_err_d;
  logic               overrun_q,      overrun_d;
  logic [3:0]         err_count_q,    err_count_d;

  ir_edge_detect u_avail_edge (
    .clk   (clk),
    .reset (reset),
    .level (avail),
    .rise  (byte_evt)
  );

  // next-state logic for framing, delivery, handshake and timers
  always_comb begin
    state_d        = state_q;
    first_byte_d   = first_byte_q;
    timer_d        = timer_q;
    repeat_armed_d = repeat_armed_q;
    last_cmd_d     = last_cmd_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_data_d     = cmd_data_q;
    cmd_repeat_d   = cmd_repeat_q;
    frame_err_d    = 1'b0;
    overrun_d      = overrun_q;
    err_count_d    = err_count_q;
    rep_timer_d    = (rep_timer_q == RPT_MAX) ? rep_timer_q : (rep_timer_q + 11'd1);

    // an accepted command retires unless a new delivery replaces it below
    if (cmd_valid_q && cmd_ack) begin
      cmd_valid_d  = 1'b0;
      cmd_repeat_d = 1'b0;
    end else begin
      cmd_valid_d  = cmd_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (byte_evt) begin
          first_byte_d = ir_byte;
          timer_d      = 11'd0;
          state_d      = WAIT_INV;
        end else begin
          state_d      = IDLE;
        end
      end
      WAIT_INV: begin
        if (byte_evt) begin
          if (is_complement(ir_byte, first_byte_q)) begin
            state_d = IDLE;
            if (!cmd_valid_q || cmd_ack) begin
              cmd_valid_d    = 1'b1;
              cmd_data_d     = first_byte_q;
              cmd_repeat_d   = repeat_armed_q && (first_byte_q == last_cmd_q) &&
                               (rep_timer_q < RPT_MAX);
              last_cmd_d     = first_byte_q;
              rep_timer_d    = 11'd0;
              repeat_armed_d = 1'b1;
            end else begin
              overrun_d      = 1'b1;
            end
          end else begin
            // mismatch: the new byte may be the start of the next frame
            frame_err_d  = 1'b1;
            err_count_d  = sat_inc4(err_count_q);
            first_byte_d = ir_byte;
            timer_d      = 11'd0;
          end
        end else if (timer_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          err_count_d = sat_inc4(err_count_q);
          state_d     = IDLE;
        end else begin
          timer_d     = timer_q + 11'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      first_byte_q   <= 8'h00;
      timer_q        <= 11'd0;
      rep_timer_q    <= 11'd0;
      repeat_armed_q <= 1'b0;
      last_cmd_q     <= 8'h00;
      cmd_valid_q    <= 1'b0;
      cmd_data_q     <= 8'h00;
      cmd_repeat_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      err_count_q    <= 4'h0;
    end else begin
      state_q        <= state_d;
      first_byte_q   <= first_byte_d;
      timer_q        <= timer_d;
      rep_timer_q    <= rep_timer_d;
      repeat_armed_q <= repeat_armed_d;
      last_cmd_q     <= last_cmd_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_data_q     <= cmd_data_d;
      cmd_repeat_q   <= cmd_repeat_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
      err_count_q    <= err_count_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_data   = cmd_data_q;
  assign cmd_repeat = cmd_repeat_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q == WAIT_INV);

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Scoreboard bench for ir_cmd_decoder: the driver queues expected deliveries
// and frame errors; a negedge monitor pops and compares them as they appear.
module tb_ir_cmd_decoder;

  localparam int TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       avail = 1'b0;
  logic [7:0] ir_byte = 8'h00;
  logic       cmd_ack = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_repeat;
  logic       frame_err;
  logic       overrun;
  logic [3:0] err_count;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       rpt;
    int         cyc;
  } dlv_t;

  typedef struct {
    logic [3:0] cnt;
    int         cyc;
  } err_t;

  dlv_t dq[$];
  err_t eq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_evt = 0;
  logic last_valid = 1'b0;
  logic last_ack = 1'b0;

  ir_cmd_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .avail      (avail),
    .ir_byte    (ir_byte),
    .cmd_ack    (cmd_ack),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_repeat (cmd_repeat),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare each new command presentation and each error pulse
  always @(negedge clk) begin
    if (reset) begin
      last_valid = 1'b0;
      last_ack   = 1'b0;
    end else begin
      if (cmd_valid && (!last_valid || last_ack)) begin
        if (dq.size() == 0) begin
          check("unexpected_cmd", {24'h0, cmd_data}, 32'hFFFF_FFFF);
        end else begin
          dlv_t d;
          d = dq.pop_front();
          check("cmd_data", {24'h0, cmd_data}, {24'h0, d.data});
          check("cmd_repeat", {31'h0, cmd_repeat}, {31'h0, d.rpt});
          if (d.cyc >= 0) check("cmd_latency", cyc, d.cyc);
        end
      end
      if (frame_err) begin
        if (eq.size() == 0) begin
          check("unexpected_frame_err", 32'h1, 32'h0);
        end else begin
          err_t e;
          e = eq.pop_front();
          check("err_count_at_pulse", {28'h0, err_count}, {28'h0, e.cnt});
          if (e.cyc >= 0) check("frame_err_cycle", cyc, e.cyc);
        end
      end
      last_valid = cmd_valid;
      last_ack   = cmd_ack;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // kind: 0 nothing expected, 1 delivery, 2 frame error at the edge, 3 timeout error
  task automatic send_byte(input logic [7:0] b, input int kind, input logic [7:0] d,
                           input logic rpt, input logic [3:0] ecnt, input logic ack_at_evt);
    dlv_t dv;
    err_t ev;
    @(posedge clk);
    #2;
    ir_byte  = b;
    avail    = 1'b1;
    cmd_ack  = ack_at_evt;
    last_evt = cyc + 1;
    if (kind == 1) begin
      dv.data = d; dv.rpt = rpt; dv.cyc = last_evt;
      dq.push_back(dv);
    end else if (kind == 2) begin
      ev.cnt = ecnt; ev.cyc = last_evt;
      eq.push_back(ev);
    end else if (kind == 3) begin
      ev.cnt = ecnt; ev.cyc = last_evt + TIMEOUT;
      eq.push_back(ev);
    end
    @(posedge clk);
    #2;
    cmd_ack = 1'b0;
    @(posedge clk);
    #2;
    avail = 1'b0;
    wait_cyc(2);
  endtask

  task automatic ack_cmd();
    @(posedge clk);
    #2;
    cmd_ack = 1'b1;
    @(posedge clk);
    #2;
    cmd_ack = 1'b0;
    check("valid_cleared_after_ack", {31'h0, cmd_valid}, 32'h0);
    check("repeat_cleared_after_ack", {31'h0, cmd_repeat}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    avail = 1'b0;
    cmd_ack = 1'b0;
    wait_cyc(3);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    wait_cyc(3);
    #2;
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_cmd_data", {24'h0, cmd_data}, 32'h0);
    check("rst_cmd_repeat", {31'h0, cmd_repeat}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_err_count", {28'h0, err_count}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    wait_cyc(2);

    // basic frame with hold until ack
    send_byte(8'h35, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("busy_after_first", {31'h0, busy}, 32'h1);
    wait_cyc(45);
    send_byte(8'hCA, 1, 8'h35, 1'b0, 4'h0, 1'b0);
    wait_cyc(10);
    check("hold_valid", {31'h0, cmd_valid}, 32'h1);
    check("hold_data", {24'h0, cmd_data}, 32'h35);
    ack_cmd();

    // mismatch then resync
    do_reset();
    send_byte(8'h35, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'h00, 2, 8'h00, 1'b0, 4'h1, 1'b0);
    check("busy_after_mismatch", {31'h0, busy}, 32'h1);
    check("errcnt_after_mismatch", {28'h0, err_count}, 32'h1);
    send_byte(8'hFF, 1, 8'h00, 1'b0, 4'h0, 1'b0);
    ack_cmd();

    // single byte times out
    do_reset();
    send_byte(8'h12, 3, 8'h00, 1'b0, 4'h1, 1'b0);
    wait_cyc(TIMEOUT + 10);
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    check("errcnt_after_timeout", {28'h0, err_count}, 32'h1);
    check("valid_after_timeout", {31'h0, cmd_valid}, 32'h0);

    // auto-repeat inside and outside the window
    do_reset();
    send_byte(8'h20, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hDF, 1, 8'h20, 1'b0, 4'h0, 1'b0);
    ack_cmd();
    wait_cyc(480);
    send_byte(8'h20, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hDF, 1, 8'h20, 1'b1, 4'h0, 1'b0);
    ack_cmd();
    wait_cyc(1500);
    send_byte(8'h20, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hDF, 1, 8'h20, 1'b0, 4'h0, 1'b0);
    ack_cmd();

    // overrun when the previous command is still pending
    do_reset();
    send_byte(8'h01, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hFE, 1, 8'h01, 1'b0, 4'h0, 1'b0);
    send_byte(8'h02, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hFD, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("overrun_data_kept", {24'h0, cmd_data}, 32'h01);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("overrun_valid_held", {31'h0, cmd_valid}, 32'h1);

    // ack in the delivery cycle lets the second command through
    do_reset();
    send_byte(8'h01, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hFE, 1, 8'h01, 1'b0, 4'h0, 1'b0);
    send_byte(8'h02, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    send_byte(8'hFD, 1, 8'h02, 1'b0, 4'h0, 1'b1);
    check("ack_cycle_data", {24'h0, cmd_data}, 32'h02);
    check("ack_cycle_overrun", {31'h0, overrun}, 32'h0);
    ack_cmd();

    // reset while busy with avail held high
    do_reset();
    send_byte(8'h35, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #2;
    ir_byte = 8'hCA;
    avail   = 1'b1;
    reset   = 1'b1;
    wait_cyc(3);
    #2;
    reset = 1'b0;
    wait_cyc(10);
    #2;
    check("held_byte_ignored_busy", {31'h0, busy}, 32'h0);
    check("held_byte_no_cmd", {31'h0, cmd_valid}, 32'h0);
    check("held_byte_errcnt", {28'h0, err_count}, 32'h0);
    avail = 1'b0;
    wait_cyc(2);
    send_byte(8'hCA, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("capture_after_reedge", {31'h0, busy}, 32'h1);
    send_byte(8'h35, 1, 8'hCA, 1'b0, 4'h0, 1'b0);
    ack_cmd();

    // error counter saturation
    send_byte(8'h11, 0, 8'h00, 1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      send_byte(8'h11, 2, 8'h00, 1'b0, (i > 15) ? 4'hF : 4'(i), 1'b0);
    end
    check("err_count_saturated", {28'h0, err_count}, 32'hF);

    wait_cyc(5);
    check("deliveries_drained", dq.size(), 32'h0);
    check("errors_drained", eq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
